// File: rtl/zxaudio_pkg.sv
// Shared constants for the zxaudio I2S transmit and receive blocks.
//   CHANNELDEPTH_DFLT : default sample width in bits
//   SYNC_DEPTH        : flops in each clock-domain-crossing synchroniser
//   I2S_LEFT/RIGHT    : lrclk encoding of the two channel slots
//   rx_state_e        : receiver lock-state encoding
package zxaudio_pkg;

  localparam int   CHANNELDEPTH_DFLT = 16;
  localparam int   SYNC_DEPTH        = 2;
  localparam logic I2S_LEFT          = 1'b0;
  localparam logic I2S_RIGHT         = 1'b1;

  typedef enum logic [1:0] {
    RX_HUNT = 2'd0,
    RX_SYNC = 2'd1,
    RX_RUN  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchroniser bank for asynchronous I2S pins.
//   edge_d_i : single bit that gets a synchroniser plus rising-edge detect (bclk)
//   d_i      : bits that only need synchronising (lrclk, sdata)
//   sync_o   : synchronised copy of d_i, same latency as the edge bit
//   rise_o   : one-cycle pulse when the synchronised edge bit goes 0 -> 1
module i2s_sync_edge
  import zxaudio_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             mclk_i,
  input  logic             rst_n_i,
  input  logic             edge_d_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic             rise_o
);

  logic [SYNC_DEPTH-1:0] edge_sync_q;
  logic                  edge_dly_q;
  logic [WIDTH-1:0]      data_sync_q [SYNC_DEPTH];

  always_ff @(posedge mclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      edge_sync_q <= '0;
      edge_dly_q  <= 1'b0;
      for (int i = 0; i < SYNC_DEPTH; i++) data_sync_q[i] <= '0;
    end else begin
      edge_sync_q    <= {edge_sync_q[SYNC_DEPTH-2:0], edge_d_i};
      edge_dly_q     <= edge_sync_q[SYNC_DEPTH-1];
      data_sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_DEPTH; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign sync_o = data_sync_q[SYNC_DEPTH-1];
  assign rise_o = edge_sync_q[SYNC_DEPTH-1] & ~edge_dly_q;

endmodule

// File: rtl/i2s_rx.sv
// Philips-format I2S receiver, oversampled by mclk.
//   mclk, reset_n          : system clock, async active-low reset
//   bclk, lrclk, sdata     : asynchronous I2S pins (mclk >= 4x bclk)
//   left_chan, right_chan  : signed samples, held between pulses
//   sample_valid           : one-cycle strobe per delivered L/R pair
//   frame_err              : one-cycle strobe when a kept word had the wrong bit count
//
// state   | meaning
// RX_HUNT | waiting for the first lrclk change; partial word discarded
// RX_SYNC | aligned, waiting for a complete left word (right words dropped)
// RX_RUN  | left words staged, right words emit a pair
module i2s_rx
  import zxaudio_pkg::*;
#(
  parameter int CHANNELDEPTH = CHANNELDEPTH_DFLT,
  parameter int BITCNT_W     = 6
) (
  input  logic                           mclk,
  input  logic                           reset_n,
  input  logic                           bclk,
  input  logic                           lrclk,
  input  logic                           sdata,
  output logic signed [CHANNELDEPTH-1:0] left_chan,
  output logic signed [CHANNELDEPTH-1:0] right_chan,
  output logic                           sample_valid,
  output logic                           frame_err
);

  localparam logic [BITCNT_W-1:0] DEPTH_CNT = BITCNT_W'(CHANNELDEPTH);

  logic [1:0] sync_vec;
  logic       rise;

  i2s_sync_edge #(.WIDTH(2)) u_sync (
    .mclk_i   (mclk),
    .rst_n_i  (reset_n),
    .edge_d_i (bclk),
    .d_i      ({sdata, lrclk}),
    .sync_o   (sync_vec),
    .rise_o   (rise)
  );

  // Edge-detect stage: rise and the data sampled with it are registered
  // together so the word logic sees a stable, aligned triple.
  logic rise_q, lr_q, sd_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      rise_q <= rise;
      lr_q   <= sync_vec[0];
      sd_q   <= sync_vec[1];
    end
  end

  rx_state_e             state_q, state_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CHANNELDEPTH-1:0] shift_q, shift_d;
  logic [CHANNELDEPTH-1:0] staging_q, staging_d;
  logic                  prev_q, prev_d;
  logic [CHANNELDEPTH-1:0] left_d, right_d;
  logic                  valid_d, err_d;

  logic                    take_bit;
  logic [CHANNELDEPTH-1:0] shift_in;
  logic [BITCNT_W-1:0]     cnt_inc;
  logic [BITCNT_W-1:0]     pad;
  logic [CHANNELDEPTH-1:0] word;
  logic                    bad_len;

  // Bits beyond CHANNELDEPTH are counted but not stored (LSB truncation);
  // short words are left-justified with zero fill.
  always_comb begin
    take_bit = (bitcnt_q < DEPTH_CNT);
    shift_in = take_bit ? {shift_q[CHANNELDEPTH-2:0], sd_q} : shift_q;
    cnt_inc  = (bitcnt_q == '1) ? bitcnt_q : bitcnt_q + 1'b1;
    pad      = DEPTH_CNT - cnt_inc;
    word     = (cnt_inc < DEPTH_CNT) ? (shift_in << pad) : shift_in;
    bad_len  = (cnt_inc != DEPTH_CNT);
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    staging_d = staging_q;
    prev_d    = prev_q;
    left_d    = left_chan;
    right_d   = right_chan;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (rise_q) begin
      if (lr_q == prev_q) begin
        shift_d  = shift_in;
        bitcnt_d = cnt_inc;
      end else begin
        // One-bit I2S delay: this bit is the LSB of the word in the old slot.
        shift_d  = '0;
        bitcnt_d = '0;
        prev_d   = lr_q;
        case (state_q)
          RX_HUNT: state_d = RX_SYNC;
          RX_SYNC: begin
            if (prev_q == I2S_LEFT) begin
              staging_d = word;
              err_d     = bad_len;
              state_d   = RX_RUN;
            end
          end
          RX_RUN: begin
            err_d = bad_len;
            if (prev_q == I2S_LEFT) begin
              staging_d = word;
            end else begin
              left_d  = staging_q;
              right_d = word;
              valid_d = 1'b1;
            end
          end
          default: state_d = RX_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RX_HUNT;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      staging_q    <= '0;
      prev_q       <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      staging_q    <= staging_d;
      prev_q       <= prev_d;
      left_chan    <= left_d;
      right_chan   <= right_d;
      sample_valid <= valid_d;
      frame_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  logic               mclk = 1'b0;
  logic               reset_n;
  logic               bclk, lrclk, sdata;
  logic signed [15:0] left_chan, right_chan;
  logic               sample_valid, frame_err;

  i2s_rx dut (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          c;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   err_pulses = 0;
  int   n_valid = 0;
  int   m_exp_err = 0;

  // Behavioural reference for which words are kept; data values are hand-supplied.
  int          m_st = 0;
  logic        m_prev = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_stage = '0;
  logic [15:0] m_last_exp = '0;
  logic        prev_lsb = 1'b0;

  task automatic model_rise(input logic lr, input logic [15:0] cur_exp);
    int   n;
    logic old;
    if (lr == m_prev) begin
      m_cnt++;
    end else begin
      n      = m_cnt + 1;
      old    = m_prev;
      m_prev = lr;
      m_cnt  = 0;
      if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1) begin
        if (old == 1'b0) begin
          m_stage = m_last_exp;
          if (n != 16) m_exp_err++;
          m_st = 2;
        end
      end else begin
        if (n != 16) m_exp_err++;
        if (old == 1'b0) m_stage = m_last_exp;
        else sb_q.push_back('{l: m_stage, r: m_last_exp, c: cyc});
      end
    end
    m_last_exp = cur_exp;
  endtask

  function automatic logic bit_at(input logic [31:0] d, input int k);
    if (k < 32) return d[31-k];
    return 1'b0;
  endfunction

  task automatic bit_period(input logic lr, input logic sd, input int half, input logic [15:0] cur_exp);
    @(negedge mclk);
    bclk = 1'b0; lrclk = lr; sdata = sd;
    repeat (half - 1) @(negedge mclk);
    @(negedge mclk);
    bclk = 1'b1;
    model_rise(lr, cur_exp);
    repeat (half - 1) @(negedge mclk);
  endtask

  // Slot bit j carries data bit j-1 (MSB-aligned in 'data'); bit 0 of the
  // slot carries the LSB of the previous word.
  task automatic send_part(input logic lr, input logic [31:0] data, input int n,
                           input logic [15:0] exp16, input int half, input int first_j, input int last_j);
    for (int j = first_j; j < last_j; j++)
      bit_period(lr, (j == 0) ? prev_lsb : bit_at(data, j - 1), half, exp16);
    if (last_j == n) prev_lsb = bit_at(data, n - 1);
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] data, input int n,
                           input logic [15:0] exp16, input int half);
    send_part(lr, data, n, exp16, half, 0, n);
  endtask

  task automatic send_frame(input logic [31:0] ld, input logic [31:0] rd, input int n,
                            input logic [15:0] le, input logic [15:0] re, input int half);
    send_slot(1'b0, ld, n, le, half);
    send_slot(1'b1, rd, n, re, half);
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic checkpoint(input string name);
    repeat (8) @(negedge mclk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_pairs: %0d pairs still pending, required 0", name, sb_q.size());
      sb_q.delete();
    end
    n_checks++;
    if (err_pulses != m_exp_err) begin
      n_errors++;
      $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, err_pulses, m_exp_err);
      err_pulses = m_exp_err;
    end
  endtask

  // Monitor: pops the scoreboard on every sample_valid.
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  exp_t e;
  always @(negedge mclk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (sample_valid) begin
        n_valid++;
        if (sb_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_valid: got L=%h R=%h, required no pulse", left_chan, right_chan);
        end else begin
          e = sb_q.pop_front();
          check_val("left_chan", left_chan, e.l);
          check_val("right_chan", right_chan, e.r);
          n_checks++;
          if (cyc - e.c != 4) begin
            n_errors++;
            $display("FAIL latency: got %0d cycles, required 4", cyc - e.c);
          end
        end
        if (prev_valid) begin
          n_checks++; n_errors++;
          $display("FAIL valid_width: got 2+ cycles high, required 1");
        end
      end
      if (frame_err) begin
        err_pulses++;
        if (prev_err) begin
          n_checks++; n_errors++;
          $display("FAIL err_width: got 2+ cycles high, required 1");
        end
      end
      prev_valid = sample_valid;
      prev_err   = frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int v_snap, e_snap;

  initial begin
    reset_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (5) @(negedge mclk);
    check_val("rst_left", left_chan, 16'h0000);
    check_val("rst_right", right_chan, 16'h0000);
    check_val("rst_valid", {15'd0, sample_valid}, 16'h0000);
    check_val("rst_err", {15'd0, frame_err}, 16'h0000);
    reset_n = 1'b1;
    repeat (4) @(negedge mclk);

    // 16-bit slots, bclk = mclk/8; first frame dropped while locking.
    repeat (3) send_frame(32'h8001_0000, 32'h7FFE_0000, 16, 16'h8001, 16'h7FFE, 4);
    send_part(1'b0, 32'h1234_5600, 24, 16'h1234, 4, 0, 1);
    checkpoint("t1_16bit");

    // 24-bit slots: LSBs truncated, frame_err per word.
    send_part(1'b0, 32'h1234_5600, 24, 16'h1234, 4, 1, 24);
    send_slot(1'b1, 32'hFEDC_BA00, 24, 16'hFEDC, 4);
    send_frame(32'h1234_5600, 32'hFEDC_BA00, 24, 16'h1234, 16'hFEDC, 4);
    send_part(1'b0, 32'hABC0_0000, 12, 16'hABC0, 4, 0, 1);
    checkpoint("t2_24bit");

    // 12-bit slots: left-justified with zero fill.
    send_part(1'b0, 32'hABC0_0000, 12, 16'hABC0, 4, 1, 12);
    send_slot(1'b1, 32'h0010_0000, 12, 16'h0010, 4);
    send_frame(32'hABC0_0000, 32'h0010_0000, 12, 16'hABC0, 16'h0010, 4);
    send_part(1'b0, 32'h1111_0000, 16, 16'h1111, 4, 0, 1);
    checkpoint("t3_12bit");

    // Reset midway through a right word, then resume the same stream.
    send_part(1'b0, 32'h1111_0000, 16, 16'h1111, 4, 1, 16);
    send_part(1'b1, 32'h2222_0000, 16, 16'h2222, 4, 0, 8);
    @(negedge mclk);
    reset_n = 1'b0; bclk = 1'b0;
    #1;
    check_val("midrst_left", left_chan, 16'h0000);
    check_val("midrst_right", right_chan, 16'h0000);
    check_val("midrst_valid", {15'd0, sample_valid}, 16'h0000);
    check_val("midrst_err", {15'd0, frame_err}, 16'h0000);
    m_st = 0; m_prev = 1'b0; m_cnt = 0;
    repeat (3) @(negedge mclk);
    reset_n = 1'b1;
    send_part(1'b1, 32'h2222_0000, 16, 16'h2222, 4, 8, 16);
    send_frame(32'h1357_0000, 32'h2468_0000, 16, 16'h1357, 16'h2468, 4);
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 16, 16'h0F0F, 16'hF0F0, 4);
    send_part(1'b0, 32'h0000_0000, 16, 16'h0000, 4, 0, 1);
    checkpoint("t4_reset");

    // Back-to-back alternating frames at bclk = mclk/4.
    send_part(1'b0, 32'h0000_0000, 16, 16'h0000, 2, 1, 16);
    send_slot(1'b1, 32'hFFFF_0000, 16, 16'hFFFF, 2);
    send_frame(32'hFFFF_0000, 32'h0000_0000, 16, 16'hFFFF, 16'h0000, 2);
    send_frame(32'h0000_0000, 32'hFFFF_0000, 16, 16'h0000, 16'hFFFF, 2);
    send_part(1'b0, 32'hC3A5_0000, 216, 16'hC3A5, 4, 0, 1);
    checkpoint("t5_fast");

    // lrclk stalled for ~200 bclk periods: silence, then one frame_err.
    send_part(1'b0, 32'hC3A5_0000, 216, 16'hC3A5, 4, 1, 3);
    v_snap = n_valid; e_snap = err_pulses;
    send_part(1'b0, 32'hC3A5_0000, 216, 16'hC3A5, 4, 3, 216);
    n_checks++;
    if (n_valid != v_snap) begin
      n_errors++;
      $display("FAIL stall_valid: got %0d pulses, required 0", n_valid - v_snap);
    end
    n_checks++;
    if (err_pulses != e_snap) begin
      n_errors++;
      $display("FAIL stall_err: got %0d pulses, required 0", err_pulses - e_snap);
    end
    send_slot(1'b1, 32'h5A5A_0000, 16, 16'h5A5A, 4);
    send_part(1'b0, 32'h0000_0000, 16, 16'h0000, 4, 0, 1);
    checkpoint("t6_stall");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver, the receive-side counterpart of the codec-facing transmitter in the zxaudio block.
- Deserialises a Philips-format I2S stream (MSB first, data delayed one bclk after each lrclk edge) into signed left/right samples in the mclk domain.
- bclk, lrclk and sdata are treated as asynchronous inputs and are oversampled by mclk.
- Delivers one stereo sample pair per frame with a single-cycle valid strobe, for the ADC/line-in path into the audio mixer.

Parameters:
- CHANNELDEPTH, 16, bits per output sample.
- BITCNT_W, 6, width of the per-word bit counter; tolerates up to 63 bits per channel slot.

Ports:
- mclk  in  1  system/master clock; all logic is on posedge mclk.
- reset_n  in  1  asynchronous active-low reset.
- bclk  in  1  I2S bit clock, async to mclk; mclk >= 4x bclk.
- lrclk  in  1  I2S word select; 0 = left, 1 = right.
- sdata  in  1  I2S serial data.
- left_chan  out  CHANNELDEPTH  signed left sample.
- right_chan  out  CHANNELDEPTH  signed right sample.
- sample_valid  out  1  one-mclk pulse when a new left/right pair is presented.
- frame_err  out  1  one-mclk pulse when a completed word had a bit count != CHANNELDEPTH.

Behaviour:
- Reset: asynchronous on reset_n low. All of the following reset to 0: left_chan, right_chan, sample_valid, frame_err, synchronisers, shift register, bit counter, staging register, locked. lrclk_prev resets to 0.
- Input conditioning:
  - Each of bclk, lrclk and sdata passes through a 2-flop synchroniser.
  - A third flop on bclk forms rise = sync_bclk & ~bclk_d.
  - All sampling happens only on the mclk cycle where rise = 1.
- On each rise, with s = sync_sdata and l = sync_lrclk:
  - Case l == lrclk_prev: a mid-word bit.
    - If bitcnt < CHANNELDEPTH, shift s into the shift register LSB-ward (MSB first).
    - Increment bitcnt, saturating at its maximum.
  - Case l != lrclk_prev: s is the final (LSB-position) bit of the word belonging to lrclk_prev, because of the I2S one-bit delay.
    - Append s under the same bitcnt rule.
    - Form the word: if total bits n < CHANNELDEPTH, left-justify and zero-pad the low bits. If n > CHANNELDEPTH, keep the first CHANNELDEPTH bits, i.e. truncate LSBs.
    - Set bitcnt = 0 and lrclk_prev = l.
    - If locked = 0: discard the word, set locked = 1, no outputs.
    - If locked = 1 and lrclk_prev was 0: write the word to the left staging register.
    - If locked = 1 and lrclk_prev was 1: load left_chan <= staging and right_chan <= word, and pulse sample_valid for 1 cycle.
    - If locked = 1 and n != CHANNELDEPTH: pulse frame_err in the same cycle the word completes. The word is still delivered.
- Latency: sample_valid rises 4 mclk cycles after the bclk rising edge (at the pins) that carries the right LSB. This is 2 synchroniser cycles + 1 edge-detect cycle + 1 output register cycle.
- Outputs hold their values between pulses. sample_valid and frame_err are never high for more than one cycle.
- Boundary conditions:
  - First partial word after reset is always dropped.
  - First pair delivered is always a complete left followed by a complete right.
  - lrclk held constant: bitcnt saturates, nothing is emitted, no error is raised until the next transition.
  - A bclk glitch narrower than 1 mclk may be missed. Behaviour is undefined and is out of scope.
  - reset_n asserted mid-word: all state is cleared immediately and the relock rule applies again.

Decomposition:
- Shared package zxaudio_pkg: CHANNELDEPTH default, the I2S channel encoding constants (LEFT = 0, RIGHT = 1), and the sync depth constant (2). The tx block uses the same constants.
- One sub-module, i2s_sync_edge: a 2-flop synchroniser plus a rising-edge detect for a single bit. It is instantiated for bclk; lrclk and sdata use its synchroniser-only path.

Test Plan:
1. Reset, then 3 frames with CHANNELDEPTH = 16, 16 bits per slot, bclk = mclk/8, L = 16'h8001, R = 16'h7FFE.
   - The first (partial) frame is dropped.
   - Then left_chan = 16'h8001 and right_chan = 16'h7FFE, with sample_valid as a 1-cycle pulse 4 mclk after the right-LSB bclk rise.
   - frame_err stays 0.
2. 24-bit slots carrying L = 24'h123456, R = 24'hFEDCBA.
   - left_chan = 16'h1234, right_chan = 16'hFEDC.
   - frame_err pulses once per word.
3. 12-bit slots carrying L = 12'hABC, R = 12'h001.
   - left_chan = 16'hABC0, right_chan = 16'h0010.
   - frame_err pulses.
4. Assert reset_n low for 3 mclk midway through a right word, then resume the stream.
   - Outputs read 0 immediately.
   - No sample_valid until one full L+R pair after relock.
5. Back-to-back frames alternating 16'h0000/16'hFFFF with bclk = mclk/4.
   - Each pair is delivered with exactly one sample_valid per frame and no missed bits.
6. Stop toggling lrclk for 200 bclk periods.
   - No sample_valid and no frame_err during the stall.
   - After lrclk resumes, the first word pulses frame_err (its count is saturated).
